spi_ram_bridge: RTL and testbench
=================================

# spi_ram_bridge

Parametrised SPI slave and single-port RAM in one block: next generation of the SPI wrapper, with configurable address/data widths and optional auto-increment burst transfers. Serial frames on MOSI/SS_n set write/read pointers, write words into the internal RAM, or stream RAM words out on MISO. The design clock is also the bit clock: one bit per `clk` rising edge while SS_n is low.

## Interface
- ADDR_W, 8, RAM address width; depth = 2**ADDR_W words.
- DATA_W, 8, RAM word width.
- clk  in  1  design clock; MOSI sampled and MISO updated on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- MOSI  in  1  serial data in, MSB first.
- SS_n  in  1  slave select, active low; frames a transaction.
- MISO  out  1  serial data out, MSB first; registered.
- busy  out  1  high whenever the FSM is not in IDLE; registered.

## Operation
- FSM states: IDLE, CMD, PAYLOAD, RD_WAIT, RD_SHIFT, DONE.
- IDLE: the first edge with SS_n=0 moves to CMD; no bit is sampled on that edge.
- CMD: the next two edges sample c1, c0. The c0 edge selects the next state: 00/01/10 → PAYLOAD, 11 → RD_WAIT.
- PAYLOAD length: ADDR_W bits for cmd 00 (write pointer) and 10 (read pointer); DATA_W bits for cmd 01 (write data).
- Last payload edge, cmd 00: wr_addr ← payload. Cmd 10: rd_addr ← payload. Cmd 01: mem[wr_addr] ← payload. Then → DONE.
- Cmd 11:
  - RD_WAIT issues a synchronous RAM read of mem[rd_addr].
  - The data loads into the shift register → RD_SHIFT.
  - RD_SHIFT drives DATA_W bits on MISO, MSB first, then → DONE.
- DONE: MISO=0; waits for SS_n=1.
- SS_n=1 on any edge in any non-IDLE state → IDLE on that edge. A partial payload is discarded: no RAM write and no pointer update. MISO ← 0.
- Pointers wrap modulo 2**ADDR_W.
- Reset values: MISO=0, busy=0, state IDLE, wr_addr=0, rd_addr=0, shift/bit counters 0. RAM contents are not reset.
- Reset asserted mid-frame aborts immediately. A frame in progress is not resumed after reset release; the master must raise SS_n and start a new frame.

## Timing
- Let edge k be the edge sampling c0=1 of cmd 11.
  - Edge k+1: RAM read issued (RD_WAIT).
  - Edge k+2: MISO = bit DATA_W-1.
  - Edge k+1+DATA_W: MISO = bit 0.
  - Edge k+2+DATA_W: MISO=0 (DONE, or next burst word).
- Write latency: the RAM is updated on the same edge that samples the last data bit. A read of the same address in a later frame returns the new value.
- Minimum frame lengths:
  - Write frame: 1 + 2 + DATA_W edges with SS_n low.
  - Read frame: 1 + 2 + 1 + DATA_W edges.
- The RAM is single-port. The FSM never issues a write and a read on the same edge, so no arbitration is needed.

## Configuration
- SPI_RAM_AUTOINC_EN defined:
  - Cmd 01: after each DATA_W-bit word, wr_addr ← wr_addr+1. PAYLOAD continues collecting further words while SS_n stays low.
  - Cmd 11: after each word, rd_addr ← rd_addr+1, then RD_WAIT (one idle MISO=0 edge) and RD_SHIFT repeat while SS_n is low.
  - Pointers wrap from 2**ADDR_W-1 to 0.
- SPI_RAM_AUTOINC_EN undefined:
  - Exactly one word per cmd 01/11 frame; pointers change only via cmd 00/10.
  - Extra bits are ignored in DONE.

## Test plan
- Reset: assert rst_n=0 mid-payload of cmd 01 → MISO=0, busy=0, wr_addr=rd_addr=0. After release, mem is unchanged.
- Round trip (8/8):
  - Stimulus: cmd 00 addr 0x3F; cmd 01 data 0xA5; cmd 10 addr 0x3F; cmd 11.
  - Required: MISO = 1,0,1,0,0,1,0,1 on edges k+2..k+9.
- Abort: cmd 01 to 0x3F with SS_n raised after 4 data bits → busy=0 next edge; a subsequent read of 0x3F still returns 0xA5.
- Burst with macro:
  - Stimulus: wr_addr 0xFF; one cmd 01 frame carrying 0x11, 0x22.
  - Required: mem[0xFF]=0x11, mem[0x00]=0x22.
  - A read burst from 0xFF streams 0x11, then 0x22 after one MISO=0 gap.
- Same burst without macro: mem[0xFF]=0x11, mem[0x00] unchanged, wr_addr stays 0xFF.
- Parameters ADDR_W=10, DATA_W=16: write 0xBEEF to 0x3FF, read back → MISO streams 0xBEEF over 16 edges.

Source files
------------

// File: rtl/spi_ram_bridge.sv
`timescale 1ns/1ps
// spi_ram_bridge: SPI slave (bit clock = clk) fronting a single-port RAM of 2**ADDR_W x DATA_W words.
// Latency: RAM write on the edge sampling the last data bit; first MISO bit two edges after the read command.
// Backpressure: none; the master paces every bit and may abort any frame by raising SS_n.
//
// Ports: clk, rst_n (async, active low), MOSI/SS_n serial in, MISO serial out (registered),
//        busy (registered, high while not IDLE).
// Commands (2 bits, MSB first): 00 set wr_addr, 01 write word, 10 set rd_addr, 11 read word.
// Optional feature macro: SPI_RAM_AUTOINC_EN enables auto-increment bursts for cmd 01/11.
module spi_ram_bridge #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic MOSI,
  input  logic SS_n,
  output logic MISO,
  output logic busy
);

  // Payload collector is sized for the longer of address and data payloads.
  localparam int PW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CW = (PW > 2) ? $clog2(PW) : 1;
  localparam logic [CW-1:0] A_LAST = CW'(ADDR_W - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, CMD, PAYLOAD, RD_WAIT, RD_SHIFT, DONE} state_t;

  state_t            state, state_n;
  logic [1:0]        cmd;
  logic [CW-1:0]     cnt, cnt_n;
  logic [PW-2:0]     pay;       // previously shifted payload bits
  logic [PW-1:0]     pay_nxt;   // payload including the bit on MOSI this edge
  logic [DATA_W-1:0] shreg;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic pay_last;
  logic wptr_ld, rptr_ld, wptr_inc, rptr_inc;
  logic mem_we, mem_rd, shift_out;

  assign pay_nxt  = {pay, MOSI};
  assign pay_last = (cnt == ((cmd == 2'b01) ? D_LAST : A_LAST));

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    wptr_ld   = 1'b0;
    rptr_ld   = 1'b0;
    wptr_inc  = 1'b0;
    rptr_inc  = 1'b0;
    mem_we    = 1'b0;
    mem_rd    = 1'b0;
    shift_out = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!SS_n) state_n = CMD;
      end
      CMD: begin
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(1)) begin
          // cmd[0] holds c1 here; MOSI is c0
          cnt_n   = '0;
          state_n = ({cmd[0], MOSI} == 2'b11) ? RD_WAIT : PAYLOAD;
        end
      end
      PAYLOAD: begin
        cnt_n = cnt + CW'(1);
        if (pay_last) begin
          cnt_n   = '0;
          state_n = DONE;
          case (cmd)
            2'b00:   wptr_ld = 1'b1;
            2'b10:   rptr_ld = 1'b1;
            default: begin
              mem_we = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
              wptr_inc = 1'b1;
              state_n  = PAYLOAD;
`endif
            end
          endcase
        end
      end
      RD_WAIT: begin
        mem_rd  = 1'b1;
        cnt_n   = '0;
        state_n = RD_SHIFT;
      end
      RD_SHIFT: begin
        shift_out = 1'b1;
        cnt_n     = cnt + CW'(1);
        if (cnt == D_LAST) begin
          cnt_n   = '0;
          state_n = DONE;
`ifdef SPI_RAM_AUTOINC_EN
          rptr_inc = 1'b1;
          state_n  = RD_WAIT;
`endif
        end
      end
      default: ; // DONE: hold until SS_n rises
    endcase
    // Deselect aborts from any active state; partial payloads are dropped.
    if (state != IDLE && SS_n) begin
      state_n   = IDLE;
      cnt_n     = '0;
      wptr_ld   = 1'b0;
      rptr_ld   = 1'b0;
      wptr_inc  = 1'b0;
      rptr_inc  = 1'b0;
      mem_we    = 1'b0;
      mem_rd    = 1'b0;
      shift_out = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      cmd     <= '0;
      pay     <= '0;
      shreg   <= '0;
      wr_addr <= '0;
      rd_addr <= '0;
      MISO    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      busy  <= (state_n != IDLE);
      if (state == CMD)     cmd <= {cmd[0], MOSI};
      if (state == PAYLOAD) pay <= pay_nxt[PW-2:0];
      if (wptr_ld)       wr_addr <= pay_nxt[ADDR_W-1:0];
      else if (wptr_inc) wr_addr <= wr_addr + ADDR_W'(1);
      if (rptr_ld)       rd_addr <= pay_nxt[ADDR_W-1:0];
      else if (rptr_inc) rd_addr <= rd_addr + ADDR_W'(1);
      if (mem_rd)         shreg <= mem[rd_addr];
      else if (shift_out) shreg <= {shreg[DATA_W-2:0], 1'b0};
      MISO <= shift_out ? shreg[DATA_W-1] : 1'b0;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= pay_nxt[DATA_W-1:0];
  end

endmodule

// File: tb/tb_spi_ram_bridge.sv
`timescale 1ns/1ps
module tb_spi_ram_bridge;
  localparam int AW = 8;
  localparam int DW = 8;
`ifdef SPI_RAM_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic mosi_a, ss_a, miso_a, busy_a;
  logic mosi_b, ss_b, miso_b, busy_b;

  always #5 clk = ~clk;

  spi_ram_bridge #(.ADDR_W(AW), .DATA_W(DW)) dut_a (
    .clk(clk), .rst_n(rst_n), .MOSI(mosi_a), .SS_n(ss_a), .MISO(miso_a), .busy(busy_a)
  );

  spi_ram_bridge #(.ADDR_W(10), .DATA_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .MOSI(mosi_b), .SS_n(ss_b), .MISO(miso_b), .busy(busy_b)
  );

  int tests = 0;
  int fails = 0;

  // Frame-level model of instance A
  logic [DW-1:0] mdl_mem [256];
  bit            mdl_vld [256];
  logic [AW-1:0] mdl_wp = '0;
  logic [AW-1:0] mdl_rp = '0;

  typedef struct packed {logic care; logic miso; logic busy;} exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Per-edge compare of instance A against expectations queued by the driver.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("busy_a", {31'd0, busy_a}, {31'd0, e.busy});
        if (e.care) chk("miso_a", {31'd0, miso_a}, {31'd0, e.miso});
      end
    end
  end

  task automatic edge_a(input logic ss, input logic mosi, input logic care,
                        input logic em, input logic eb, output logic got);
    exp_t e;
    @(negedge clk);
    ss_a = ss;
    mosi_a = mosi;
    e.care = care; e.miso = em; e.busy = eb;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = miso_a;
  endtask

  // One SS_n-low frame on A (select, c1, c0, npay edges) followed by one deselect edge.
  task automatic frame_a(input logic [1:0] cmd, input logic [31:0] pay, input int npay,
                         output logic [DW-1:0] rd0, output logic [DW-1:0] rd1);
    logic g, b, care, em;
    logic [AW-1:0] a;
    int acc, done_words, L, P, w, r;
    rd0 = '0; rd1 = '0; acc = 0; done_words = 0;
    edge_a(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, g);
    edge_a(1'b0, cmd[1], 1'b1, 1'b0, 1'b1, g);
    edge_a(1'b0, cmd[0], 1'b1, 1'b0, 1'b1, g);
    L = (cmd == 2'b01) ? DW : AW;
    P = DW + 1;
    for (int j = 0; j < npay; j++) begin
      if (cmd != 2'b11) begin
        b = pay[npay-1-j];
        edge_a(1'b0, b, 1'b1, 1'b0, 1'b1, g);
        acc = (acc << 1) | int'(b);
        if (j % L == L - 1) begin
          w = j / L;
          case (cmd)
            2'b00: if (w == 0) mdl_wp = AW'(acc);
            2'b10: if (w == 0) mdl_rp = AW'(acc);
            default: if (w == 0 || AUTOINC) begin
              mdl_mem[mdl_wp] = DW'(acc);
              mdl_vld[mdl_wp] = 1'b1;
              if (AUTOINC) mdl_wp = mdl_wp + AW'(1);
            end
          endcase
          acc = 0;
        end
      end else begin
        // Each word: one idle edge (read issue) then DW data bits MSB first.
        w = j / P; r = j % P; care = 1'b1; em = 1'b0;
        if (r != 0 && (w == 0 || AUTOINC)) begin
          a = mdl_rp + AW'(w);
          em = mdl_mem[a][DW-r];
          care = mdl_vld[a];
        end
        edge_a(1'b0, 1'b0, care, em, 1'b1, g);
        if (r != 0 && w == 0) rd0[DW-r] = g;
        if (r != 0 && w == 1) rd1[DW-r] = g;
        if (r == DW && (w == 0 || AUTOINC)) done_words++;
      end
    end
    if (AUTOINC) mdl_rp = mdl_rp + AW'(done_words);
    edge_a(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, g);
  endtask

  task automatic edge_b(input logic ss, input logic mosi, output logic got);
    @(negedge clk);
    ss_b = ss;
    mosi_b = mosi;
    @(posedge clk);
    #1;
    got = miso_b;
  endtask

  task automatic frame_b(input logic [1:0] cmd, input logic [31:0] pay, input int npay,
                         output logic [15:0] rd);
    logic g;
    rd = '0;
    edge_b(1'b0, 1'b0, g);
    edge_b(1'b0, cmd[1], g);
    edge_b(1'b0, cmd[0], g);
    for (int j = 0; j < npay; j++) begin
      edge_b(1'b0, (cmd == 2'b11) ? 1'b0 : pay[npay-1-j], g);
      if (cmd == 2'b11 && j == 0) chk("b_rdwait_miso", {31'd0, g}, 32'd0);
      if (cmd == 2'b11 && j >= 1 && j <= 16) rd[16-j] = g;
    end
    edge_b(1'b1, 1'b0, g);
    chk("b_busy_after_frame", {31'd0, busy_b}, 32'd0);
  endtask

  initial begin
    logic [DW-1:0] x, y;
    logic [15:0] wb;
    logic g;
    rst_n = 1'b0;
    ss_a = 1'b1; mosi_a = 1'b0;
    ss_b = 1'b1; mosi_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_miso_a", {31'd0, miso_a}, 32'd0);
    chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
    chk("rst_miso_b", {31'd0, miso_b}, 32'd0);
    chk("rst_busy_b", {31'd0, busy_b}, 32'd0);
    rst_n = 1'b1;
    edge_a(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, g);

    // Pointers start at 0: write without setting wr_addr, read without setting rd_addr.
    frame_a(2'b01, 32'h3C, 8, x, y);
    frame_a(2'b11, 32'h0, 9, x, y);
    chk("rst_ptr_roundtrip", {24'd0, x}, 32'h3C);

    // Round trip at 0x3F.
    frame_a(2'b00, 32'h3F, 8, x, y);
    frame_a(2'b01, 32'hA5, 8, x, y);
    frame_a(2'b10, 32'h3F, 8, x, y);
    frame_a(2'b11, 32'h0, 9, x, y);
    chk("roundtrip_A5", {24'd0, x}, 32'hA5);

    // Reset in the middle of a cmd 01 payload.
    frame_a(2'b00, 32'h10, 8, x, y);
    frame_a(2'b01, 32'h77, 8, x, y);
    frame_a(2'b10, 32'h20, 8, x, y);
    edge_a(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, g);
    edge_a(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, g);
    edge_a(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, g);
    edge_a(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, g);
    edge_a(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, g);
    edge_a(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, g);
    edge_a(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, g);
    @(negedge clk);
    rst_n = 1'b0;
    ss_a = 1'b1;
    #1;
    chk("midrst_miso", {31'd0, miso_a}, 32'd0);
    chk("midrst_busy", {31'd0, busy_a}, 32'd0);
    mdl_wp = '0;
    mdl_rp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    edge_a(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, g);
    frame_a(2'b01, 32'h66, 8, x, y);
    frame_a(2'b11, 32'h0, 9, x, y);
    chk("post_rst_ptrs", {24'd0, x}, 32'h66);
    frame_a(2'b10, 32'h10, 8, x, y);
    frame_a(2'b11, 32'h0, 9, x, y);
    chk("mem_kept_over_rst", {24'd0, x}, 32'h77);

    // Abort after 4 data bits leaves 0x3F intact.
    frame_a(2'b00, 32'h3F, 8, x, y);
    frame_a(2'b01, 32'h5, 4, x, y);
    frame_a(2'b10, 32'h3F, 8, x, y);
    frame_a(2'b11, 32'h0, 9, x, y);
    chk("abort_kept_A5", {24'd0, x}, 32'hA5);

    // Two-word frame at the top of the address space.
    frame_a(2'b00, 32'hFF, 8, x, y);
    frame_a(2'b01, 32'h1122, 16, x, y);
    frame_a(2'b10, 32'hFF, 8, x, y);
    frame_a(2'b11, 32'h0, 18, x, y);
    chk("burst_w0", {24'd0, x}, 32'h11);
`ifdef SPI_RAM_AUTOINC_EN
    chk("burst_w1", {24'd0, y}, 32'h22);
`else
    chk("noburst_miso_idle", {24'd0, y}, 32'h0);
`endif
    frame_a(2'b10, 32'h00, 8, x, y);
    frame_a(2'b11, 32'h0, 9, x, y);
`ifdef SPI_RAM_AUTOINC_EN
    chk("mem0_after_burst", {24'd0, x}, 32'h22);
`else
    chk("mem0_after_burst", {24'd0, x}, 32'h66);
`endif
    frame_a(2'b01, 32'h33, 8, x, y);
    frame_a(2'b10, 32'hFF, 8, x, y);
    frame_a(2'b11, 32'h0, 9, x, y);
`ifdef SPI_RAM_AUTOINC_EN
    chk("wr_ptr_after_burst", {24'd0, x}, 32'h11);
`else
    chk("wr_ptr_after_burst", {24'd0, x}, 32'h33);
`endif

    // Wide instance: 10-bit address, 16-bit data.
    frame_b(2'b00, 32'h3FF, 10, wb);
    frame_b(2'b01, 32'hBEEF, 16, wb);
    frame_b(2'b10, 32'h3FF, 10, wb);
    frame_b(2'b11, 32'h0, 17, wb);
    chk("wide_BEEF", {16'd0, wb}, 32'hBEEF);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
